uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_ctrl_if.sv | 28 ++
 rtl/uart_rx_fifo.sv | 49 ++++
 rtl/uart_rx_ctrl.sv | 92 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared frame layout and receive-controller state encoding.
package uart_pkg;

  localparam int FRAME_W      = 11;
  localparam int FRM_START    = 0;
  localparam int FRM_DATA_LSB = 1;
  localparam int FRM_DATA_MSB = 8;
  localparam int FRM_PAR      = 9;
  localparam int FRM_STOP     = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_STORE = 2'd2,
    ST_DROP  = 2'd3
  } rx_state_e;

  // Framing is broken when the start bit is not low or the stop bit is not high.
  function automatic logic framing_bad(input logic [FRAME_W-1:0] f);
    return (f[FRM_START] != 1'b0) || (f[FRM_STOP] != 1'b1);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the serial receiver, the consumer and the receive controller.
interface uart_rx_ctrl_if;
  // Handshakes: recieved_flag is a one-cycle frame-complete pulse with data_parll valid
  // in that cycle (no back-pressure). rx_data is transferred on every rising edge where
  // rx_valid and rx_ready are both 1; rx_valid does not depend on rx_ready.
  logic        rx_en;
  logic        recieved_flag;
  logic [10:0] data_parll;
  logic        rx_ready;
  logic        err_clr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        parity_err;
  logic        overrun_err;
  logic [4:0]  fifo_count;
  logic        busy;

  modport master (
    output rx_en, recieved_flag, data_parll, rx_ready, err_clr,
    input  rx_data, rx_valid, frame_err, parity_err, overrun_err, fifo_count, busy
  );

  modport slave (
    input  rx_en, recieved_flag, data_parll, rx_ready, err_clr,
    output rx_data, rx_valid, frame_err, parity_err, overrun_err, fifo_count, busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; push is accepted when full if a pop happens on the same edge.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [4:0] count,
  output logic       full,
  output logic       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_eff;
  logic          push_eff;

  assign empty    = (count == 5'd0);
  assign full     = (count == 5'(DEPTH));
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign dout     = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: validates completed UART frames and buffers good data bytes.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic          baud_clk,
  input  logic          rst_n,
  uart_rx_ctrl_if.slave bus,
  output rx_state_e     dbg_state
);
  rx_state_e          state;
  logic [FRAME_W-1:0] hold;
  logic               push_q;
  logic               frame_err_q;
  logic               parity_err_q;
  logic               overrun_err_q;
  logic               frame_bad;
  logic               parity_bad;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               flag_seen;

  assign frame_bad  = framing_bad(hold);
  assign parity_bad = PARITY_EN && ((^hold[FRM_PAR:FRM_DATA_LSB]) != PARITY_ODD);
  assign fifo_pop   = !fifo_empty && bus.rx_ready;
  assign flag_seen  = bus.recieved_flag && bus.rx_en;

  // The push is issued one edge after STORE, so the full check uses the FIFO state
  // on the edge where the byte actually lands (a simultaneous pop makes room).
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      hold          <= '1;
      push_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (bus.err_clr) begin
        frame_err_q   <= 1'b0;
        parity_err_q  <= 1'b0;
        overrun_err_q <= 1'b0;
      end
      if (push_q && fifo_full && !fifo_pop) overrun_err_q <= 1'b1;
      if (state != ST_IDLE && flag_seen) overrun_err_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (flag_seen) begin
            hold  <= bus.data_parll;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: state <= (frame_bad || parity_bad) ? ST_DROP : ST_STORE;
        ST_STORE: begin
          push_q <= 1'b1;
          state  <= ST_IDLE;
        end
        ST_DROP: begin
          if (frame_bad) frame_err_q  <= 1'b1;
          else           parity_err_q <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (baud_clk),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (fifo_pop),
    .din   (hold[FRM_DATA_MSB:FRM_DATA_LSB]),
    .dout  (bus.rx_data),
    .count (bus.fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.rx_valid    = !fifo_empty;
  assign bus.frame_err   = frame_err_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.overrun_err = overrun_err_q;
  assign bus.busy        = (state != ST_IDLE);
  assign dbg_state       = state;
endmodule
